// File: rtl/shared_word_memory_if.sv
// Request/response bundle between the core cluster and the shared word memory.
interface shared_word_memory_if #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]           req;
  logic [NUM_PORTS-1:0]           we;
  logic [NUM_PORTS*ADDR_BITS-1:0] addr;
  logic [NUM_PORTS*DATA_BITS-1:0] wdata;
  logic                           clear;
  logic [NUM_PORTS-1:0]           gnt;
  logic [NUM_PORTS-1:0]           rvalid;
  logic [DATA_BITS-1:0]           rdata;
  logic                           ready;

  modport master (output req, we, addr, wdata, clear, input gnt, rvalid, rdata, ready);
  modport slave  (input req, we, addr, wdata, clear, output gnt, rvalid, rdata, ready);
endinterface

// File: rtl/shared_word_memory.sv
// Single-port word RAM shared by NUM_PORTS cores through a round-robin arbiter,
// with a clear engine that zeroes the array after reset or on request.
module shared_word_memory #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_word_memory_if.slave  bus
);
  localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
  localparam int unsigned PTR_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_BITS-1:0]   cnt, cnt_nxt;
  logic [PTR_BITS-1:0]    ptr, ptr_nxt;
  logic [NUM_PORTS-1:0]   gnt_c;
  logic                   granted;
  int unsigned            idx;
  logic                   acc_we;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic [DATA_BITS-1:0]   acc_wdata;
  logic                   ready;
  logic [NUM_PORTS-1:0]   rvalid;
  logic [DATA_BITS-1:0]   rdata;
  logic [DATA_BITS-1:0]   mem [DEPTH];

  // Next state, clear counter and round-robin grant search starting at ptr
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_c     = '0;
    idx       = 0;
    case (state)
      S_CLEAR: begin
        cnt_nxt = cnt + ADDR_BITS'(1);
        if (cnt == ADDR_BITS'(DEPTH - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.clear) begin
          state_nxt = S_CLEAR;
        end else begin
          for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
              if (gnt_c == '0 && i == idx && bus.req[i]) begin
                gnt_c[i] = 1'b1;
                ptr_nxt  = (i == NUM_PORTS - 1) ? '0 : PTR_BITS'(i + 1);
              end
            end
          end
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign granted = |gnt_c;

  // Route the granted port's command onto the single RAM port
  always_comb begin
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gnt_c[i]) begin
        acc_we    = bus.we[i];
        acc_addr  = bus.addr[i*ADDR_BITS +: ADDR_BITS];
        acc_wdata = bus.wdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_CLEAR;
      cnt    <= '0;
      ptr    <= '0;
      ready  <= 1'b0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ptr    <= ptr_nxt;
      ready  <= (state_nxt == S_RUN);
      rvalid <= (granted && !acc_we) ? gnt_c : '0;
      if (granted && !acc_we) rdata <= mem[acc_addr];
    end
  end

  // RAM array has no reset; the clear engine owns it while in CLEAR
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) mem[cnt] <= '0;
    else if (granted && acc_we) mem[acc_addr] <= acc_wdata;
  end

  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rvalid;
  assign bus.rdata  = rdata;
  assign bus.ready  = ready;
endmodule

// File: tb/tb_shared_word_memory.sv
// Directed bench for shared_word_memory: stimulus pushes expected read returns,
// an independent monitor pops and compares them on every rvalid.
module tb_shared_word_memory;
  localparam int unsigned AB    = 10;
  localparam int unsigned DB    = 8;
  localparam int unsigned NP    = 4;
  localparam int          DEPTH = 1024;

  typedef struct {
    int             port;
    logic [DB-1:0]  data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  shared_word_memory_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_PORTS(NP)) bus ();

  shared_word_memory #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_PORTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AB-1:0] a, input logic [DB-1:0] d);
    bus.req[p]            = r;
    bus.we[p]             = w;
    bus.addr[p*AB +: AB]  = a;
    bus.wdata[p*DB +: DB] = d;
  endtask

  // One cycle with a single requester; for reads d is the expected data
  task automatic single(input int p, input logic w, input logic [AB-1:0] a, input logic [DB-1:0] d);
    @(posedge clk); #1;
    bus.req = '0;
    bus.we  = '0;
    set_port(p, 1'b1, w, a, d);
    @(negedge clk);
    check(w ? "wr_gnt" : "rd_gnt", 32'(bus.gnt), 32'(1) << p);
    if (!w) exp_q.push_back('{port: p, data: d});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.req = '0;
    bus.we  = '0;
    @(negedge clk);
  endtask

  // Counts rising edges until ready is seen high, bounded
  task automatic wait_ready(input string name, input int exp_edges);
    int n;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!bus.ready && n < 3000);
    check(name, 32'(n), 32'(exp_edges));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(bus.ready),  32'd0);
    check({tag, "_gnt"},    32'(bus.gnt),    32'd0);
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    check({tag, "_rdata"},  32'(bus.rdata),  32'd0);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rvalid != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", 32'(bus.rvalid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid", 32'(bus.rvalid), 32'(1) << e.port);
          check("rdata",  32'(bus.rdata),  32'(e.data));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bus.req   = '1;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req = '0;
    wait_ready("por_clear_len", DEPTH);

    // Reset while in RUN after preloading 0xAA
    single(0, 1'b1, 10'd0,    8'hAA);
    single(0, 1'b1, 10'd511,  8'hAA);
    single(0, 1'b1, 10'd1023, 8'hAA);
    single(3, 1'b0, 10'd1023, 8'hAA);
    idle();
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 10'd0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_run");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req = '0;
    wait_ready("rst_clear_len", DEPTH);
    single(1, 1'b0, 10'd0,    8'h00);
    single(1, 1'b0, 10'd511,  8'h00);
    single(1, 1'b0, 10'd1023, 8'h00);
    idle();

    // Write then back-to-back read on port 2
    single(2, 1'b1, 10'h3FF, 8'h5C);
    single(2, 1'b0, 10'h3FF, 8'h5C);
    idle();

    // Round-robin: preload 0..3, leaving the pointer at 0
    for (int p = 0; p < 4; p++) single(p, 1'b1, AB'(p), DB'(8'h10 + p));
    @(posedge clk); #1;
    bus.req = '0;
    for (int p = 0; p < 4; p++) begin
      set_port(p, 1'b1, 1'b0, AB'(p), 8'h00);
      exp_q.push_back('{port: p, data: DB'(8'h10 + p)});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_gnt", 32'(bus.gnt), 32'(1) << k);
      @(posedge clk); #1;
      bus.req[k] = 1'b0;
    end
    single(0, 1'b0, 10'd0, 8'h10);

    // Contention between ports 1 and 3
    @(posedge clk); #1;
    bus.req = '0;
    set_port(1, 1'b1, 1'b0, 10'd1, 8'h00);
    set_port(3, 1'b1, 1'b0, 10'd3, 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'b0010 : 32'b1000);
      if (k % 2 == 0) exp_q.push_back('{port: 1, data: 8'h11});
      else            exp_q.push_back('{port: 3, data: 8'h13});
      @(posedge clk); #1;
    end
    bus.req = '0;

    // Clear pulse in RUN while port 0 requests
    single(0, 1'b1, 10'h010, 8'h77);
    @(posedge clk); #1;
    bus.req = '0;
    bus.we  = '0;
    set_port(0, 1'b1, 1'b0, 10'h010, 8'h00);
    bus.clear = 1'b1;
    @(negedge clk);
    check("clear_gnt", 32'(bus.gnt), 32'd0);
    @(posedge clk); #1;
    bus.clear = 1'b0;
    @(negedge clk);
    check("clear_ready_drop", 32'(bus.ready), 32'd0);
    check("clear_gnt_wait",   32'(bus.gnt),   32'd0);
    wait_ready("clear_len", DEPTH);
    @(negedge clk);
    check("post_clear_gnt", 32'(bus.gnt), 32'b0001);
    exp_q.push_back('{port: 0, data: 8'h00});
    idle();

    // Reset 300 edges into a clear, with rdata holding a non-zero value
    single(1, 1'b1, 10'd5, 8'h5A);
    single(1, 1'b0, 10'd5, 8'h5A);
    idle();
    @(posedge clk); #1;
    bus.req   = '1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    repeat (299) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_clear");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req = '0;
    wait_ready("midclear_len", DEPTH);
    single(2, 1'b0, 10'd5, 8'h00);
    idle();
    idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
